// File: rtl/neural_pkg.sv
// Types and constants shared by the network stages: argmax FSM states, index-width helper, default datawidth.
package neural_pkg;

   localparam int DEFAULT_DATAWIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } argmax_state_t;

   // A single-class vector still needs a 1-bit index port.
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/argmax_classifier_if.sv
// Vector-in / class-out handshake bundle for argmax_classifier; class_score exists only with ARGMAX_SCORE_EN.
interface argmax_classifier_if #(
   parameter int DATAWIDTH     = neural_pkg::DEFAULT_DATAWIDTH,
   parameter int INPUT_NEURONS = 10
);
   localparam int INDEX_WIDTH = neural_pkg::index_width(INPUT_NEURONS);

   logic [DATAWIDTH*INPUT_NEURONS-1:0] input_data;
   logic                               in_valid;
   logic                               in_ready;
   logic [INDEX_WIDTH-1:0]             class_index;
   logic                               out_valid;
   logic                               out_ready;
`ifdef ARGMAX_SCORE_EN
   logic [DATAWIDTH-1:0]               class_score;
`endif

   modport master (
      output input_data, in_valid, out_ready,
      input  in_ready, class_index, out_valid
`ifdef ARGMAX_SCORE_EN
      , class_score
`endif
   );

   modport slave (
      input  input_data, in_valid, out_ready,
      output in_ready, class_index, out_valid
`ifdef ARGMAX_SCORE_EN
      , class_score
`endif
   );

endinterface

// File: rtl/argmax_compare.sv
// Combinational argmax step: candidate replaces the running best only when strictly greater (signed).
module argmax_compare
   import neural_pkg::*;
#(
   parameter int DATAWIDTH   = DEFAULT_DATAWIDTH,
   parameter int INDEX_WIDTH = 4
) (
   input  logic signed [DATAWIDTH-1:0]   cand,
   input  logic        [INDEX_WIDTH-1:0] cand_idx,
   input  logic signed [DATAWIDTH-1:0]   best,
   input  logic        [INDEX_WIDTH-1:0] best_idx,
   output logic signed [DATAWIDTH-1:0]   next_best,
   output logic        [INDEX_WIDTH-1:0] next_idx
);

   // Strict compare keeps the earlier index on ties.
   always_comb begin
      next_best = best;
      next_idx  = best_idx;
      if (cand > best) begin
         next_best = cand;
         next_idx  = cand_idx;
      end
   end

endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: latches a packed score vector, scans one element per cycle for the signed max (ties -> lowest index); out_valid INPUT_NEURONS-1 cycles after accept.
// Result held until out_ready; next vector accepted only after handoff. ARGMAX_SCORE_EN adds the class_score output.
module argmax_classifier
   import neural_pkg::*;
#(
   parameter int DATAWIDTH     = DEFAULT_DATAWIDTH,
   parameter int INPUT_NEURONS = 10
) (
   input  logic          clock,
   input  logic          reset,
   argmax_classifier_if.slave bus
);

   localparam int INDEX_WIDTH = index_width(INPUT_NEURONS);
   localparam int VEC_WIDTH   = DATAWIDTH * INPUT_NEURONS;
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(INPUT_NEURONS - 1);

   argmax_state_t state, state_nxt;

   logic [VEC_WIDTH-1:0]          vec;
   logic signed [DATAWIDTH-1:0]   best;
   logic signed [DATAWIDTH-1:0]   cand;
   logic signed [DATAWIDTH-1:0]   next_best;
   logic [INDEX_WIDTH-1:0]        best_idx;
   logic [INDEX_WIDTH-1:0]        next_idx;
   logic [INDEX_WIDTH-1:0]        idx;
   logic                          in_ready_c;
   logic                          out_valid_c;
   logic                          accept;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = (INPUT_NEURONS == 1) ? DONE : SCAN;
         end
         SCAN: begin
            if (idx == LAST_IDX) state_nxt = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = in_ready_c & bus.in_valid;
   assign cand   = vec[idx*DATAWIDTH +: DATAWIDTH];

   argmax_compare #(
      .DATAWIDTH   (DATAWIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_compare (
      .cand      (cand),
      .cand_idx  (idx),
      .best      (best),
      .best_idx  (best_idx),
      .next_best (next_best),
      .next_idx  (next_idx)
   );

   // Element 0 seeds the running best, so the scan starts at index 1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vec      <= '0;
         best     <= '0;
         best_idx <= '0;
         idx      <= '0;
      end else if (accept) begin
         vec      <= bus.input_data;
         best     <= bus.input_data[DATAWIDTH-1:0];
         best_idx <= '0;
         idx      <= INDEX_WIDTH'(1);
      end else if (state == SCAN) begin
         best     <= next_best;
         best_idx <= next_idx;
         idx      <= idx + 1'b1;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.class_index = best_idx;
`ifdef ARGMAX_SCORE_EN
   assign bus.class_score = best;
`endif

endmodule
